// File: rtl/matvec_call_sequencer.sv
// matvec_call_sequencer: queues (M, V, Out0) argument triples and issues them as matvec
// component calls over a start/busy handshake, consumes done/stall returns, tracks calls in
// flight, counts completions and pulses irq when everything drains.
// Optional feature: define MATVEC_SEQ_CYCLE_COUNT_EN to build the saturating busy_cycles
// counter; otherwise busy_cycles is tied to zero.
module matvec_call_sequencer #(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_m,
    input  logic [63:0]      cmd_v,
    input  logic [63:0]      cmd_out,
    output logic             call_start,
    input  logic             call_busy,
    output logic [63:0]      call_m,
    output logic [63:0]      call_v,
    output logic [63:0]      call_out,
    input  logic             ret_done,
    output logic             ret_stall,
    input  logic             hold_returns,
    output logic [7:0]       inflight,
    output logic [CNT_W-1:0] done_count,
    output logic             irq,
    output logic             proto_err,
    output logic [31:0]      busy_cycles
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QC_W  = PTR_W + 1;
    localparam logic [QC_W-1:0]  QC_FULL = QC_W'(DEPTH);
    localparam logic [QC_W-1:0]  QC_ONE  = QC_W'(1);
    localparam logic [QC_W-1:0]  QC_ZERO = QC_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [7:0]       INF_MAX = 8'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_THROTTLE = 2'd2
    } state_t;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state, w_state_nxt;
    logic [63:0]      r_q_m   [DEPTH];
    logic [63:0]      r_q_v   [DEPTH];
    logic [63:0]      r_q_out [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_head_idx;
    logic [QC_W-1:0]  r_q_count, w_q_count_nxt;
    logic             r_cmd_ready, r_call_start, r_irq, r_proto_err;
    logic [63:0]      r_call_m, r_call_v, r_call_out;
    logic [7:0]       r_inflight, w_infl_nxt;
    logic [CNT_W-1:0] r_done_count;
    logic             w_enq, w_accept, w_ret, w_ret_ok, w_ret_err, w_irq_set;
    logic             w_load, w_load_next;

    // Reset synchroniser: assertion is immediate, release is aligned to the clock.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_enq       = cmd_valid & r_cmd_ready;
    assign w_accept    = r_call_start & ~call_busy;
    assign w_ret       = ret_done & ~hold_returns;
    assign w_ret_ok    = w_ret & (r_inflight != 8'd0);
    assign w_ret_err   = w_ret & (r_inflight == 8'd0);
    assign w_infl_nxt  = r_inflight + (w_accept ? 8'd1 : 8'd0) - (w_ret_ok ? 8'd1 : 8'd0);
    assign w_q_count_nxt = r_q_count + (w_enq ? QC_ONE : QC_ZERO) - (w_accept ? QC_ONE : QC_ZERO);
    assign w_head_idx  = w_load_next ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    // Drain: the last in-flight call returns with nothing queued, presented or arriving.
    assign w_irq_set   = w_ret_ok & (r_inflight == 8'd1) & ~w_accept & (r_q_count == QC_ZERO)
                         & ~r_call_start & ~w_enq;

    // FSM state register.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state and call-register load controls.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && (r_q_count != QC_ZERO) && (w_infl_nxt < INF_MAX)) begin
                    w_state_nxt = ST_LAUNCH;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (w_accept) begin
                    // Back-to-back needs a second entry behind the one being popped.
                    if (enable && (r_q_count > QC_ONE) && (w_infl_nxt < INF_MAX)) begin
                        w_state_nxt = ST_LAUNCH;
                        w_load      = 1'b1;
                        w_load_next = 1'b1;
                    end else if (w_infl_nxt == INF_MAX) begin
                        w_state_nxt = ST_THROTTLE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_THROTTLE: begin
                if (w_infl_nxt < INF_MAX) begin
                    if (enable && (r_q_count != QC_ZERO)) begin
                        w_state_nxt = ST_LAUNCH;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_THROTTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Queue storage: write the incoming triple at the tail.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_m[i]   <= 64'd0;
                r_q_v[i]   <= 64'd0;
                r_q_out[i] <= 64'd0;
            end
        end else if (w_enq) begin
            r_q_m[r_wr_ptr]   <= cmd_m;
            r_q_v[r_wr_ptr]   <= cmd_v;
            r_q_out[r_wr_ptr] <= cmd_out;
        end else begin
            r_q_m[r_wr_ptr]   <= r_q_m[r_wr_ptr];
            r_q_v[r_wr_ptr]   <= r_q_v[r_wr_ptr];
            r_q_out[r_wr_ptr] <= r_q_out[r_wr_ptr];
        end
    end

    // Queue pointers, occupancy and registered ready flag; the head pops on call accept.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_q_count   <= QC_ZERO;
            r_cmd_ready <= 1'b1;
        end else begin
            r_wr_ptr    <= w_enq    ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
            r_rd_ptr    <= w_accept ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
            r_q_count   <= w_q_count_nxt;
            r_cmd_ready <= (w_q_count_nxt != QC_FULL);
        end
    end

    // Call presentation: start and arguments are held until the callee accepts.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_call_start <= 1'b0;
            r_call_m     <= 64'd0;
            r_call_v     <= 64'd0;
            r_call_out   <= 64'd0;
        end else if (w_load) begin
            r_call_start <= 1'b1;
            r_call_m     <= r_q_m[w_head_idx];
            r_call_v     <= r_q_v[w_head_idx];
            r_call_out   <= r_q_out[w_head_idx];
        end else if (w_accept) begin
            r_call_start <= 1'b0;
        end else begin
            r_call_start <= r_call_start;
        end
    end

    // In-flight tracking, completion count, drain interrupt and sticky protocol error.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_inflight   <= 8'd0;
            r_done_count <= {CNT_W{1'b0}};
            r_irq        <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_inflight   <= w_infl_nxt;
            r_done_count <= w_ret_ok ? (r_done_count + {{(CNT_W-1){1'b0}}, 1'b1}) : r_done_count;
            r_irq        <= w_irq_set;
            r_proto_err  <= r_proto_err | w_ret_err;
        end
    end

`ifdef MATVEC_SEQ_CYCLE_COUNT_EN
    logic [31:0] r_busy_cycles;

    // Saturating count of clocks with work queued, presented or in flight.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_busy_cycles <= 32'd0;
        end else if (((r_inflight != 8'd0) || (r_q_count != QC_ZERO) || r_call_start)
                     && (r_busy_cycles != 32'hFFFF_FFFF)) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end else begin
            r_busy_cycles <= r_busy_cycles;
        end
    end
    assign busy_cycles = r_busy_cycles;
`else
    assign busy_cycles = 32'd0;
`endif

    assign cmd_ready  = r_cmd_ready;
    assign call_start = r_call_start;
    assign call_m     = r_call_m;
    assign call_v     = r_call_v;
    assign call_out   = r_call_out;
    assign ret_stall  = hold_returns;
    assign inflight   = r_inflight;
    assign done_count = r_done_count;
    assign irq        = r_irq;
    assign proto_err  = r_proto_err;

endmodule
